// File: rtl/trace_stream_serialiser.sv
// trace_stream_serialiser: buffers 128-bit trace records in a FIFO and emits each as four AXI-Stream beats.
module trace_stream_serialiser #(
  parameter int FIFO_DEPTH   = 8,
  parameter int TDATA_WIDTH  = 32,
  parameter int RECORD_WIDTH = 128
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              rec_valid,
  input  logic [RECORD_WIDTH-1:0]           rec_in,
  output logic [TDATA_WIDTH-1:0]            m_axis_tdata,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready,
  output logic                              m_axis_tlast,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic [15:0]                       dropped_count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_d;
  logic [1:0] idx, idx_d;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [RECORD_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [3:0][TDATA_WIDTH-1:0] beats;
  logic push, pop;
  logic [LW-1:0] level_d;
  // beats[3] is the record MSB word, so beat index idx maps to beats[~idx]
  always_comb begin
    beats = mem[rd_ptr];
    pop = state == SEND && m_axis_tready && idx == 2'd3;
    push = rec_valid && (fifo_level < LW'(FIFO_DEPTH) || pop);
    level_d = fifo_level + LW'(push) - LW'(pop);
    m_axis_tvalid = state == SEND;
    m_axis_tlast = m_axis_tvalid && idx == 2'd3;
    m_axis_tdata = m_axis_tvalid ? beats[~idx] : '0;
    state_d = state;
    idx_d = idx;
    if (state == IDLE) begin
      state_d = fifo_level != '0 ? SEND : IDLE;
      idx_d = '0;
    end else if (m_axis_tready) begin
      idx_d = idx + 2'd1;
      if (pop) state_d = level_d != '0 ? SEND : IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_level <= '0;
      dropped_count <= '0;
    end else begin
      state <= state_d;
      idx <= idx_d;
      fifo_level <= level_d;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      if (rec_valid && !push && dropped_count != 16'hFFFF) dropped_count <= dropped_count + 16'd1;
    end
  end
  // a push into a full FIFO only happens alongside a pop, so it reuses the slot being freed
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rec_in;
  end
endmodule
